// File: rtl/data_mem_lat.sv
// Word-organised big-endian data memory with byte-enable stores, misalignment
// detection, a boot write port and a configurable-latency load pipeline.
module data_mem_lat #(
  parameter int D_ADDRESSWIDTH  = 32,
  parameter int DM_DATAWIDTH    = 32,
  parameter int DM_ADDRESSWIDTH = 8,
  parameter int DM_SIZE         = 256,
  parameter int LOAD_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  output logic                      stalled,
  input  logic [3:0]                op,
  input  logic [D_ADDRESSWIDTH-1:0] d_address,
  input  logic [31:0]               d_writedata,
  output logic [31:0]               d_loadresult,
  output logic                      misaligned,
  input  logic [31:0]               boot_daddr,
  input  logic [31:0]               boot_ddata,
  input  logic                      boot_dwe
);

  localparam int AW = DM_ADDRESSWIDTH;
  localparam logic [1:0] CNT_INIT = 2'(LOAD_LATENCY - 1);

  if (DM_DATAWIDTH != 32) begin : g_bad_width
    $error("data_mem_lat: DM_DATAWIDTH must be 32");
  end
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 4) begin : g_bad_latency
    $error("data_mem_lat: LOAD_LATENCY must be 1..4");
  end
  if (DM_SIZE > (2 ** DM_ADDRESSWIDTH)) begin : g_bad_size
    $error("data_mem_lat: DM_SIZE exceeds the word-index range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [31:0]   mem [DM_SIZE];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          acc_mis;
  logic          accept, ld_accept, st_accept, st_we, rd_en;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   rd_p [LOAD_LATENCY];
  logic [1:0]    ld_off_p0, ld_size_p0;
  logic          ld_sign_p0, ld_mis_p0;
  logic          mis_q;
  logic [31:0]   ld_xlat, ld_hold;
  logic          unused_ok;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] o);
    logic r;
    case (size)
      2'b11:   r = 1'b0;
      2'b01:   r = o[0];
      default: r = (o != 2'b00);
    endcase
    return r;
  endfunction

  // Lane select by big-endian offset, then sign/zero extension; faulted loads read as zero.
  function automatic logic [31:0] load_xlat(input logic [31:0] w, input logic [1:0] o,
                                            input logic [1:0] size, input logic sgn,
                                            input logic bad);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (o)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = o[1] ? w[15:0] : w[31:16];
    case (size)
      2'b11:   r = sgn ? 32'(b) : {24'h0, b};
      2'b01:   r = sgn ? 32'(h) : {16'h0, h};
      default: r = w;
    endcase
    if (bad) r = '0;
    return r;
  endfunction

  assign idx       = d_address[AW+1:2];
  assign off       = d_address[1:0];
  assign acc_mis   = is_misaligned(op[1:0], off);
  assign accept    = resetn && en && (state == IDLE);
  assign ld_accept = accept && !op[3];
  assign st_accept = accept && op[3];
  assign st_we     = st_accept && !d_address[D_ADDRESSWIDTH-1] && !acc_mis;
  assign rd_en     = ld_accept;
  assign unused_ok = ^{d_address[D_ADDRESSWIDTH-1:AW+2], boot_daddr[31:AW]};

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = d_writedata;
    case (op[1:0])
      2'b11: begin
        st_be    = 4'b1000 >> off;
        st_wdata = {4{d_writedata[7:0]}};
      end
      2'b01: begin
        st_be    = off[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{d_writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Storage array: boot write is issued last so it overrides a same-word store.
  always_ff @(posedge clk) begin
    if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    if (boot_dwe) mem[boot_daddr[AW-1:0]] <= boot_ddata;
  end

  // Stage p0: request capture and synchronous read; later stages only add delay.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_off_p0  <= '0;
      ld_size_p0 <= '0;
      ld_sign_p0 <= 1'b0;
      ld_mis_p0  <= 1'b0;
      mis_q      <= 1'b0;
      for (int i = 0; i < LOAD_LATENCY; i++) rd_p[i] <= '0;
    end else begin
      if (accept) mis_q <= acc_mis;
      if (ld_accept) begin
        ld_off_p0  <= off;
        ld_size_p0 <= op[1:0];
        ld_sign_p0 <= op[2];
        ld_mis_p0  <= acc_mis;
      end
      if (rd_en) rd_p[0] <= mem[idx];
      for (int i = 1; i < LOAD_LATENCY; i++) rd_p[i] <= rd_p[i-1];
    end
  end

  assign ld_xlat = load_xlat(rd_p[LOAD_LATENCY-1], ld_off_p0, ld_size_p0, ld_sign_p0, ld_mis_p0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              ld_hold <= '0;
    else if (state == DONE)   ld_hold <= ld_xlat;
  end

  assign d_loadresult = (state == DONE) ? ld_xlat : ld_hold;
  assign misaligned   = mis_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // WAIT leaves once the decremented count reaches zero, so DONE lands in cycle T+LOAD_LATENCY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stalled  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_accept) begin
          stalled  = 1'b1;
          cnt_nx   = CNT_INIT;
          state_nx = (LOAD_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stalled = 1'b1;
        cnt_nx  = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_lat.sv
// Bench for data_mem_lat: three instances (load latency 1, 3, 4) checked against
// a byte-addressed big-endian memory model.
module tb_data_mem_lat;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en     [N];
  logic [3:0]  op     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        stalled[N];
  logic [31:0] ldres  [N];
  logic        mis    [N];
  logic [31:0] baddr  [N];
  logic [31:0] bdata  [N];
  logic        bwe    [N];

  int checks = 0;
  int errors = 0;
  int rd_cnt1 = 0;
  logic [7:0] mb [N][1024];

  always #5 clk = ~clk;

  data_mem_lat #(.LOAD_LATENCY(1)) u0 (
    .clk(clk), .resetn(resetn), .en(en[0]), .stalled(stalled[0]), .op(op[0]),
    .d_address(addr[0]), .d_writedata(wdata[0]), .d_loadresult(ldres[0]),
    .misaligned(mis[0]), .boot_daddr(baddr[0]), .boot_ddata(bdata[0]), .boot_dwe(bwe[0]));
  data_mem_lat #(.LOAD_LATENCY(3)) u1 (
    .clk(clk), .resetn(resetn), .en(en[1]), .stalled(stalled[1]), .op(op[1]),
    .d_address(addr[1]), .d_writedata(wdata[1]), .d_loadresult(ldres[1]),
    .misaligned(mis[1]), .boot_daddr(baddr[1]), .boot_ddata(bdata[1]), .boot_dwe(bwe[1]));
  data_mem_lat #(.LOAD_LATENCY(4)) u2 (
    .clk(clk), .resetn(resetn), .en(en[2]), .stalled(stalled[2]), .op(op[2]),
    .d_address(addr[2]), .d_writedata(wdata[2]), .d_loadresult(ldres[2]),
    .misaligned(mis[2]), .boot_daddr(baddr[2]), .boot_ddata(bdata[2]), .boot_dwe(bwe[2]));

  // Memory-port read counter on the latency-3 instance.
  always @(posedge clk) if (u1.rd_en) rd_cnt1 <= rd_cnt1 + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic bit exp_mis(input logic [3:0] o, input logic [31:0] a);
    if (o[1:0] == 2'b11) return 1'b0;
    if (o[1:0] == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input int k, input logic [3:0] o, input logic [31:0] a);
    int b;
    logic [31:0] v;
    b = int'(a[9:0]);
    if (exp_mis(o, a)) return 32'h0;
    case (o[1:0])
      2'b11:   v = o[2] ? {{24{mb[k][b][7]}}, mb[k][b]} : {24'h0, mb[k][b]};
      2'b01:   v = o[2] ? {{16{mb[k][b][7]}}, mb[k][b], mb[k][b+1]} : {16'h0, mb[k][b], mb[k][b+1]};
      default: v = {mb[k][b], mb[k][b+1], mb[k][b+2], mb[k][b+3]};
    endcase
    return v;
  endfunction

  task automatic model_store(input int k, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[9:0]);
    if (exp_mis(o, a) || a[31]) return;
    case (o[1:0])
      2'b11: mb[k][b] = d[7:0];
      2'b01: begin mb[k][b] = d[15:8]; mb[k][b+1] = d[7:0]; end
      default: for (int j = 0; j < 4; j++) mb[k][b+j] = d[31-8*j -: 8];
    endcase
  endtask

  task automatic model_boot(input int k, input logic [7:0] idx, input logic [31:0] d);
    for (int j = 0; j < 4; j++) mb[k][int'(idx)*4 + j] = d[31-8*j -: 8];
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues one store; leaves en high so a following request is back-to-back.
  task automatic do_store(input int k, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] d, output logic st, output logic m_after);
    en[k] = 1'b1; op[k] = o; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    st = stalled[k];
    step();
    m_after = mis[k];
    model_store(k, o, a, d);
  endtask

  // Holds a load request until stalled drops, bounded by a cycle budget.
  task automatic do_load(input int k, input logic [3:0] o, input logic [31:0] a,
                         output logic [31:0] res, output int ns, output bit to,
                         output logic m_after, output logic [31:0] held);
    bit done;
    done = 1'b0; ns = 0; res = '0;
    en[k] = 1'b1; op[k] = o; addr[k] = a;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (stalled[k] === 1'b1) ns++;
      else begin done = 1'b1; res = ldres[k]; end
      step();
    end
    en[k] = 1'b0;
    to = !done;
    m_after = mis[k];
    @(negedge clk);
    held = ldres[k];
    step();
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b1; op[k] = 4'b0000; addr[k] = '0; wdata[k] = '0;
      baddr[k] = '0; bdata[k] = '0; bwe[k] = 1'b0;
    end
    #2 resetn = 1'b0;
    #10;
    for (int k = 0; k < N; k++) begin
      checks++; if (stalled[k] !== 1'b0) begin errors++; $display("FAIL reset_stalled k=%0d got %b want 0", k, stalled[k]); end
      checks++; if (ldres[k] !== 32'h0) begin errors++; $display("FAIL reset_result k=%0d got %h want 0", k, ldres[k]); end
      checks++; if (mis[k] !== 1'b0) begin errors++; $display("FAIL reset_mis k=%0d got %b want 0", k, mis[k]); end
      en[k] = 1'b0;
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic boot_fill();
    logic [31:0] d;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < N; k++) begin
        d = $urandom;
        baddr[k] = 32'(i); bdata[k] = d; bwe[k] = 1'b1;
        model_boot(k, 8'(i), d);
      end
      step();
    end
    for (int k = 0; k < N; k++) bwe[k] = 1'b0;
  endtask

  task automatic test_basic_loads();
    logic [3:0]  lops [3] = '{4'b0111, 4'b0011, 4'b0101};
    logic [31:0] lads [3] = '{32'h11, 32'h13, 32'h12};
    logic [31:0] lexp [3] = '{32'h22, 32'h44, 32'h3344};
    logic st, m; logic [31:0] r, h; int ns; bit to;
    do_store(0, 4'b1000, 32'h10, 32'h11223344, st, m);
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL basic_sw_stall got %b want 0", st); end
    for (int i = 0; i < 3; i++) begin
      do_load(0, lops[i], lads[i], r, ns, to, m, h);
      checks++; if (r !== lexp[i]) begin errors++; $display("FAIL basic_load%0d got %h want %h", i, r, lexp[i]); end
      checks++; if (to || ns != 1) begin errors++; $display("FAIL basic_stall%0d got %0d want 1", i, ns); end
      checks++; if (h !== lexp[i]) begin errors++; $display("FAIL basic_hold%0d got %h want %h", i, h, lexp[i]); end
    end
  endtask

  task automatic test_byte_store();
    logic st, m; logic [31:0] r, h; int ns; bit to;
    do_store(0, 4'b1000, 32'h20, 32'hFFFFFFFF, st, m);
    do_store(0, 4'b1011, 32'h21, 32'h123456A5, st, m);
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL sb_mis got %b want 0", m); end
    do_load(0, 4'b0000, 32'h20, r, ns, to, m, h);
    checks++; if (r !== 32'hFFA5FFFF) begin errors++; $display("FAIL sb_lw got %h want ffa5ffff", r); end
    do_load(0, 4'b0111, 32'h21, r, ns, to, m, h);
    checks++; if (r !== 32'hFFFFFFA5) begin errors++; $display("FAIL sb_lb got %h want ffffffa5", r); end
  endtask

  task automatic test_latency3();
    logic st, m; logic [31:0] r, h; int ns, rd0; bit to;
    do_store(1, 4'b1000, 32'h40, 32'h80017F00, st, m);
    en[1] = 1'b0;
    step();
    rd0 = rd_cnt1;
    do_load(1, 4'b0000, 32'h40, r, ns, to, m, h);
    checks++; if (to || ns != 3) begin errors++; $display("FAIL lat3_stall got %0d want 3", ns); end
    checks++; if (r !== 32'h80017F00) begin errors++; $display("FAIL lat3_lw got %h want 80017f00", r); end
    checks++; if (rd_cnt1 - rd0 != 1) begin errors++; $display("FAIL lat3_reads got %0d want 1", rd_cnt1 - rd0); end
    do_load(1, 4'b0101, 32'h40, r, ns, to, m, h);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lat3_lh got %h want ffff8001", r); end
    do_load(1, 4'b0001, 32'h42, r, ns, to, m, h);
    checks++; if (r !== 32'h00007F00) begin errors++; $display("FAIL lat3_lhu got %h want 00007f00", r); end
  endtask

  task automatic test_misaligned();
    logic st, m; logic [31:0] r, h; int ns; bit to;
    do_store(0, 4'b1000, 32'h30, 32'hCAFEF00D, st, m);
    do_store(0, 4'b1101, 32'h31, 32'h0000BEEF, st, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_sh got %b want 1", m); end
    do_load(0, 4'b0000, 32'h30, r, ns, to, m, h);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_unchanged got %h want cafef00d", r); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_clear_load got %b want 0", m); end
    do_store(0, 4'b1101, 32'h31, 32'h0000BEEF, st, m);
    do_store(0, 4'b1000, 32'h34, 32'h01020304, st, m);
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_clear_sw got %b want 0", m); end
    do_load(0, 4'b0000, 32'h32, r, ns, to, m, h);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mis_load_zero got %h want 0", r); end
    checks++; if (to || ns != 1 || m !== 1'b1) begin errors++; $display("FAIL mis_load_timing got stall=%0d mis=%b want 1/1", ns, m); end
  endtask

  task automatic test_boot_collision();
    logic st, m; logic [31:0] r, h; int ns; bit to;
    en[0] = 1'b1; op[0] = 4'b1000; addr[0] = 32'h10; wdata[0] = 32'h12345678;
    baddr[0] = 32'd4; bdata[0] = 32'hDEADBEEF; bwe[0] = 1'b1;
    step();
    en[0] = 1'b0; bwe[0] = 1'b0;
    model_store(0, 4'b1000, 32'h10, 32'h12345678);
    model_boot(0, 8'd4, 32'hDEADBEEF);
    en[0] = 1'b1; op[0] = 4'b1000; addr[0] = 32'h18; wdata[0] = 32'hA0A1A2A3;
    baddr[0] = 32'd5; bdata[0] = 32'hB0B1B2B3; bwe[0] = 1'b1;
    step();
    en[0] = 1'b0; bwe[0] = 1'b0;
    model_store(0, 4'b1000, 32'h18, 32'hA0A1A2A3);
    model_boot(0, 8'd5, 32'hB0B1B2B3);
    do_load(0, 4'b0000, 32'h10, r, ns, to, m, h);
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL boot_wins got %h want deadbeef", r); end
    do_load(0, 4'b0000, 32'h14, r, ns, to, m, h);
    checks++; if (r !== 32'hB0B1B2B3) begin errors++; $display("FAIL boot_other got %h want b0b1b2b3", r); end
    do_load(0, 4'b0000, 32'h18, r, ns, to, m, h);
    checks++; if (r !== 32'hA0A1A2A3) begin errors++; $display("FAIL store_other got %h want a0a1a2a3", r); end
    do_store(0, 4'b1000, 32'h80000010, 32'h55555555, st, m);
    do_load(0, 4'b0000, 32'h10, r, ns, to, m, h);
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL mmio_store got %h want deadbeef", r); end
  endtask

  task automatic test_back_to_back();
    logic st, m; logic [31:0] r, h; int ns; bit to;
    for (int i = 0; i < 4; i++) begin
      do_store(2, 4'b1000, 32'h50 + 32'(4*i), 32'hC0DE0000 + 32'(i), st, m);
      checks++; if (st !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got %b want 0", i, st); end
    end
    do_load(2, 4'b0000, 32'h5C, r, ns, to, m, h);
    checks++; if (r !== 32'hC0DE0003) begin errors++; $display("FAIL raw_load got %h want c0de0003", r); end
    checks++; if (to || ns != 4) begin errors++; $display("FAIL raw_stall got %0d want 4", ns); end
    for (int i = 0; i < 3; i++) begin
      do_load(2, 4'b0000, 32'h50 + 32'(4*i), r, ns, to, m, h);
      checks++; if (r !== 32'hC0DE0000 + 32'(i)) begin errors++; $display("FAIL b2b_load%0d got %h want %h", i, r, 32'hC0DE0000 + 32'(i)); end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] r, h, r2; int ns; bit to; logic m;
    do_load(2, 4'b0000, 32'h50, r, ns, to, m, h);
    en[2] = 1'b1; op[2] = 4'b0101; addr[2] = 32'h41;
    step();
    step();
    checks++; if (ldres[2] !== 32'hC0DE0000 || mis[2] !== 1'b1) begin errors++; $display("FAIL rstw_pre got %h/%b want c0de0000/1", ldres[2], mis[2]); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (stalled[2] !== 1'b0) begin errors++; $display("FAIL rstw_stalled got %b want 0", stalled[2]); end
    checks++; if (ldres[2] !== 32'h0) begin errors++; $display("FAIL rstw_result got %h want 0", ldres[2]); end
    checks++; if (mis[2] !== 1'b0) begin errors++; $display("FAIL rstw_mis got %b want 0", mis[2]); end
    en[2] = 1'b0;
    step();
    resetn = 1'b1;
    step();
    r2 = exp_load(2, 4'b0000, 32'h54);
    do_load(2, 4'b0000, 32'h54, r, ns, to, m, h);
    checks++; if (r !== r2) begin errors++; $display("FAIL rstw_after got %h want %h", r, r2); end
    checks++; if (to || ns != 4) begin errors++; $display("FAIL rstw_after_stall got %0d want 4", ns); end
  endtask

  task automatic test_random();
    logic st, m; logic [31:0] r, h, a, d, e; logic [3:0] o; int ns; bit to;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 40; i++) begin
        o = 4'($urandom_range(0, 15));
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
        d = $urandom;
        if (o[3]) begin
          do_store(k, o, a, d, st, m);
          checks++; if (st !== 1'b0 || m !== exp_mis(o, a)) begin errors++; $display("FAIL rnd_store k=%0d op=%b a=%h got stall=%b mis=%b want 0/%b", k, o, a, st, m, exp_mis(o, a)); end
        end else begin
          e = exp_load(k, o, a);
          do_load(k, o, a, r, ns, to, m, h);
          checks++; if (r !== e) begin errors++; $display("FAIL rnd_load k=%0d op=%b a=%h got %h want %h", k, o, a, r, e); end
          checks++; if (to || ns != lat(k) || m !== exp_mis(o, a)) begin errors++; $display("FAIL rnd_timing k=%0d got stall=%0d mis=%b want %0d/%b", k, ns, m, lat(k), exp_mis(o, a)); end
        end
      end
      en[k] = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    boot_fill();
    test_basic_loads();
    test_byte_store();
    test_latency3();
    test_misaligned();
    test_boot_collision();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
